// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice engine: FSM states,
// waveform select, per-voice note record and MIDI field widths.
package synth_pkg;

  localparam int MIDI_NOTE_W = 7;
  localparam int MIDI_VEL_W  = 7;
  localparam int AGE_W       = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  typedef enum logic {
    WAVE_SAW    = 1'b0,
    WAVE_SQUARE = 1'b1
  } wave_mode_t;

  typedef struct packed {
    logic [MIDI_NOTE_W-1:0] note;
    logic [MIDI_VEL_W-1:0]  velocity;
  } voice_t;

  typedef struct packed {
    logic                   on;
    logic [MIDI_NOTE_W-1:0] note;
    logic [MIDI_VEL_W-1:0]  velocity;
  } note_event_t;

endpackage

// File: rtl/poly_voice_engine_if.sv
// Event, tick and sample signals between the MIDI parser side and the voice engine.
interface poly_voice_engine_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_W   = 12
);
  logic                  inSampleTick;
  logic                  inEventValid;
  logic                  outEventReady;
  logic                  inEventOn;
  logic [6:0]            inNote;
  logic [6:0]            inVelocity;
  logic [PHASE_W-1:0]    inStep;
  logic                  inWaveMode;
  logic [SAMPLE_W-1:0]   outSample;
  logic                  outSampleReady;
  logic [NUM_VOICES-1:0] outActiveMask;
  logic                  outDropped;

  modport master (
    output inSampleTick, inEventValid, inEventOn, inNote, inVelocity, inStep, inWaveMode,
    input  outEventReady, outSample, outSampleReady, outActiveMask, outDropped
  );

  modport slave (
    input  inSampleTick, inEventValid, inEventOn, inNote, inVelocity, inStep, inWaveMode,
    output outEventReady, outSample, outSampleReady, outActiveMask, outDropped
  );
endinterface

// File: rtl/voice_wave.sv
// Shared waveform unit: top phase bits -> signed sawtooth/square sample,
// scaled by MIDI velocity (127 is treated as just under unity).
module voice_wave
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic [SAMPLE_W-1:0]        phaseTop,
  input  logic [MIDI_VEL_W-1:0]      velocity,
  input  wave_mode_t                 waveMode,
  output logic signed [SAMPLE_W-1:0] term
);
  localparam int PROD_W = SAMPLE_W + MIDI_VEL_W + 1;

  logic signed [SAMPLE_W-1:0] wave;
  logic signed [PROD_W-1:0]   prod;

  function automatic logic signed [SAMPLE_W-1:0] scaleByVelocity(input logic signed [PROD_W-1:0] p);
    return SAMPLE_W'(p >>> MIDI_VEL_W);
  endfunction

  always_comb begin
    if (waveMode == WAVE_SQUARE)
      wave = phaseTop[SAMPLE_W-1] ? {1'b0, {(SAMPLE_W-1){1'b1}}} : {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      wave = {~phaseTop[SAMPLE_W-1], phaseTop[SAMPLE_W-2:0]};
    prod = PROD_W'(wave) * $signed({{(PROD_W-MIDI_VEL_W){1'b0}}, velocity});
    term = scaleByVelocity(prod);
  end
endmodule

// File: rtl/poly_voice_engine.sv
// Polyphonic phase-accumulator voice engine, one voice mixed per clock after each sample tick.
// Build option POLY_VOICE_STEAL_EN: steal the oldest voice when all are busy instead of dropping.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_W   = 12
) (
  input logic CLK_50MHZ,
  input logic IN_RESET,
  poly_voice_engine_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t state, stateNext;
  logic [NUM_VOICES-1:0] active;
  voice_t                voice [NUM_VOICES];
  logic [PHASE_W-1:0]    step  [NUM_VOICES];
  logic [PHASE_W-1:0]    phase [NUM_VOICES];
  logic [AGE_W-1:0]      age   [NUM_VOICES];

  note_event_t        pend, evt;
  logic [PHASE_W-1:0] pendStep, evtStep;
  logic               pendFull;

  logic accept, evApply, capture, isNoteOn;
  logic matchHit, freeHit, allocHit, doAlloc, doOff, doDrop;
  logic [IDX_W-1:0] matchIdx, freeIdx, allocIdx;

  logic [IDX_W-1:0]           idx;
  logic signed [ACC_W-1:0]    acc, accNext;
  wave_mode_t                 waveMode;
  logic [PHASE_W-1:0]         nextPhase;
  logic signed [SAMPLE_W-1:0] termRaw, term;
  logic [SAMPLE_W-1:0]        sampleReg;
  logic                       sampleReady;
  logic                       droppedReg;

  // Divide the voice sum back to one voice's range and recentre on mid-scale.
  function automatic logic [SAMPLE_W-1:0] toOffsetBinary(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] scaled;
    scaled = a >>> IDX_W;
    return SAMPLE_W'(scaled) ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
  endfunction

  // Events are applied only in IDLE; a held-over pending event takes priority.
  assign accept  = bus.inEventValid && !pendFull;
  assign evApply = (state == IDLE) && (pendFull || accept);
  assign capture = (state != IDLE) && accept;

  always_comb begin
    evt     = pend;
    evtStep = pendStep;
    if (!pendFull) begin
      evt     = '{on: bus.inEventOn, note: bus.inNote, velocity: bus.inVelocity};
      evtStep = bus.inStep;
    end
  end

  assign isNoteOn = evt.on && (evt.velocity != '0);

  always_comb begin
    matchHit = 1'b0;
    matchIdx = '0;
    freeHit  = 1'b0;
    freeIdx  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!matchHit && active[i] && voice[i].note == evt.note) begin
        matchHit = 1'b1;
        matchIdx = IDX_W'(i);
      end
      if (!freeHit && !active[i]) begin
        freeHit = 1'b1;
        freeIdx = IDX_W'(i);
      end
    end
  end

`ifdef POLY_VOICE_STEAL_EN
  logic [IDX_W-1:0] stealIdx;
  logic [AGE_W-1:0] bestAge;

  always_comb begin
    stealIdx = '0;
    bestAge  = age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > bestAge) begin
        bestAge  = age[i];
        stealIdx = IDX_W'(i);
      end
    end
  end

  assign allocHit = 1'b1;
  assign allocIdx = matchHit ? matchIdx : (freeHit ? freeIdx : stealIdx);
`else
  assign allocHit = matchHit || freeHit;
  assign allocIdx = matchHit ? matchIdx : freeIdx;
`endif

  assign doAlloc = evApply && isNoteOn && allocHit;
  assign doDrop  = evApply && isNoteOn && !allocHit;
  assign doOff   = evApply && !isNoteOn && matchHit;

  always_ff @(posedge CLK_50MHZ) begin
    if (IN_RESET) pendFull <= 1'b0;
    else if (capture) pendFull <= 1'b1;
    else if (state == IDLE) pendFull <= 1'b0;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (capture) begin
      pend     <= evt;
      pendStep <= evtStep;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (IN_RESET) begin
      active     <= '0;
      droppedReg <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        age[i]   <= '0;
      end
    end else begin
      droppedReg <= doDrop;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (doAlloc && IDX_W'(i) == allocIdx) begin
          active[i] <= 1'b1;
          phase[i]  <= '0;
          age[i]    <= '0;
        end else begin
          if (doOff && IDX_W'(i) == matchIdx) active[i] <= 1'b0;
          if (doAlloc && active[i] && age[i] != AGE_MAX) age[i] <= age[i] + 1'b1;
          if (state == ACCUM && IDX_W'(i) == idx && active[i]) phase[i] <= nextPhase;
        end
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (doAlloc) begin
      voice[allocIdx] <= '{note: evt.note, velocity: evt.velocity};
      step[allocIdx]  <= evtStep;
    end
  end

  // Shared datapath: the voice selected by idx advances and adds its term.
  assign nextPhase = phase[idx] + step[idx];

  voice_wave #(.SAMPLE_W(SAMPLE_W)) waveUnit (
    .phaseTop (nextPhase[PHASE_W-1 -: SAMPLE_W]),
    .velocity (voice[idx].velocity),
    .waveMode (waveMode),
    .term     (termRaw)
  );

  assign term    = active[idx] ? termRaw : '0;
  assign accNext = acc + {{IDX_W{term[SAMPLE_W-1]}}, term};

  always_ff @(posedge CLK_50MHZ) begin
    if (IN_RESET) state <= IDLE;
    else state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    sampleReady = 1'b0;
    case (state)
      IDLE:  if (bus.inSampleTick) stateNext = ACCUM;
      ACCUM: if (idx == LAST_IDX) stateNext = OUT;
      OUT: begin
        stateNext   = IDLE;
        sampleReady = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (IN_RESET) begin
      idx       <= '0;
      sampleReg <= {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      if (state == IDLE) idx <= '0;
      else if (state == ACCUM) idx <= idx + 1'b1;
      if (state == ACCUM && idx == LAST_IDX) sampleReg <= toOffsetBinary(accNext);
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (state == IDLE && bus.inSampleTick) begin
      acc      <= '0;
      waveMode <= wave_mode_t'(bus.inWaveMode);
    end else if (state == ACCUM) begin
      acc <= accNext;
    end
  end

  assign bus.outEventReady  = !pendFull;
  assign bus.outSample      = sampleReg;
  assign bus.outSampleReady = sampleReady;
  assign bus.outActiveMask  = active;
  assign bus.outDropped     = droppedReg;
endmodule

// File: tb/tb_poly_voice_engine.sv
// Randomized bench for poly_voice_engine against a note-level reference model of the voice pool.
module tb_poly_voice_engine;
  localparam int NV = 4;
  localparam int PW = 24;
  localparam int SW = 12;
  localparam longint PHASE_MOD  = longint'(1) << PW;
  localparam int     SAMPLE_MOD = 1 << SW;

  logic CLK_50MHZ = 1'b0;
  logic IN_RESET  = 1'b1;

  poly_voice_engine_if #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW)) bus ();

  poly_voice_engine #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW)) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .IN_RESET  (IN_RESET),
    .bus       (bus)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  int nChecks = 0;
  int nPass   = 0;

  bit     mActive [NV];
  int     mNote   [NV];
  int     mVel    [NV];
  int     mAge    [NV];
  longint mPhase  [NV];
  longint mStep   [NV];

  task automatic checkVal(input string tag, input longint got, input longint exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int floorDiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
    return q;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NV; i++) begin
      mActive[i] = 0;
      mPhase[i]  = 0;
      mAge[i]    = 0;
    end
  endtask

  function automatic int modelMask();
    int m;
    m = 0;
    for (int i = 0; i < NV; i++) if (mActive[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic modelEvent(input bit on, input int note, input int vel, input longint stp, output bit dropped);
    int match, free, tgt;
    match = -1; free = -1; tgt = -1; dropped = 0;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && mActive[i] && mNote[i] == note) match = i;
      if (free < 0 && !mActive[i]) free = i;
    end
    if (on && vel != 0) begin
      if (match >= 0) tgt = match;
      else if (free >= 0) tgt = free;
      else begin
`ifdef POLY_VOICE_STEAL_EN
        tgt = 0;
        for (int i = 1; i < NV; i++) if (mAge[i] > mAge[tgt]) tgt = i;
`else
        dropped = 1;
`endif
      end
      if (!dropped) begin
        for (int i = 0; i < NV; i++)
          if (i != tgt && mActive[i] && mAge[i] < 15) mAge[i]++;
        mActive[tgt] = 1;
        mNote[tgt]   = note;
        mVel[tgt]    = vel;
        mStep[tgt]   = stp;
        mPhase[tgt]  = 0;
        mAge[tgt]    = 0;
      end
    end else if (match >= 0) begin
      mActive[match] = 0;
    end
  endtask

  // Each sounding voice advances one step, then contributes its velocity-scaled waveform.
  function automatic int modelTick(input bit sq);
    int sum, top, wave;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (mActive[i]) begin
        mPhase[i] = (mPhase[i] + mStep[i]) % PHASE_MOD;
        top = int'(mPhase[i] / (PHASE_MOD / SAMPLE_MOD));
        if (sq) wave = (top >= SAMPLE_MOD / 2) ? SAMPLE_MOD / 2 - 1 : -(SAMPLE_MOD / 2);
        else wave = top - SAMPLE_MOD / 2;
        sum += floorDiv(wave * mVel[i], 128);
      end
    end
    return floorDiv(sum, NV) + SAMPLE_MOD / 2;
  endfunction

  task automatic stepClk();
    @(posedge CLK_50MHZ);
    #1;
  endtask

  task automatic driveIdle();
    bus.inSampleTick = 1'b0;
    bus.inEventValid = 1'b0;
    bus.inEventOn    = 1'b0;
    bus.inNote       = '0;
    bus.inVelocity   = '0;
    bus.inStep       = '0;
    bus.inWaveMode   = 1'b0;
  endtask

  task automatic doReset();
    driveIdle();
    IN_RESET = 1'b1;
    stepClk();
    stepClk();
    IN_RESET = 1'b0;
    modelReset();
  endtask

  // Called just after the tick edge; bounded wait for the strobe.
  task automatic waitSample(input int expS);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    while (cnt < NV + 10 && !seen) begin
      stepClk();
      cnt++;
      if (bus.outSampleReady) seen = 1;
    end
    checkVal("latency", seen ? cnt + 1 : -1, NV + 1);
    if (seen) begin
      checkVal("sample", bus.outSample, expS);
      stepClk();
      checkVal("strobeOneCycle", bus.outSampleReady, 0);
      checkVal("sampleHold", bus.outSample, expS);
    end
  endtask

  task automatic cycleDrive(input bit doEvt, input bit on, input int note, input int vel,
                            input int stp, input bit doTick, input bit sq);
    bit expDrop;
    int expS;
    expDrop = 0;
    bus.inEventValid = doEvt;
    bus.inEventOn    = on;
    bus.inNote       = 7'(note);
    bus.inVelocity   = 7'(vel);
    bus.inStep       = PW'(stp);
    bus.inSampleTick = doTick;
    bus.inWaveMode   = sq;
    if (doEvt) checkVal("eventReady", bus.outEventReady, 1);
    stepClk();
    bus.inEventValid = 1'b0;
    bus.inSampleTick = 1'b0;
    if (doEvt) modelEvent(on, note, vel, longint'(stp), expDrop);
    checkVal("activeMask", bus.outActiveMask, modelMask());
    if (doEvt) checkVal("dropped", bus.outDropped, expDrop);
    if (doTick) begin
      expS = modelTick(sq);
      waitSample(expS);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  expS, cnt, strobeAt, readyAt, strobes;
    bit  dummy, doEvt, doTick, on;
    int  r, note, vel, stp;

    driveIdle();
    IN_RESET = 1'b1;
    stepClk();
    stepClk();
    IN_RESET = 1'b0;
    modelReset();
    checkVal("rstSample", bus.outSample, 'h800);
    checkVal("rstSampleReady", bus.outSampleReady, 0);
    checkVal("rstEventReady", bus.outEventReady, 1);
    checkVal("rstMask", bus.outActiveMask, 0);
    checkVal("rstDropped", bus.outDropped, 0);

    repeat (3) cycleDrive(0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));

    // Single full-velocity square voice, long enough to see the phase MSB flip.
    cycleDrive(1, 1, 69, 127, 'h00A3D7, 0, 0);
    repeat (420) cycleDrive(0, 0, 0, 0, 0, 1, 1);

    // Retrigger of the same note at half velocity.
    doReset();
    cycleDrive(1, 1, 60, 127, 'h12345, 0, 0);
    repeat (5) cycleDrive(0, 0, 0, 0, 0, 1, 0);
    cycleDrive(1, 1, 60, 64, 'h12345, 0, 0);
    repeat (5) cycleDrive(0, 0, 0, 0, 0, 1, 0);

    // Fill all voices (event and tick together), then a fifth note-on.
    doReset();
    for (int k = 0; k < NV; k++) cycleDrive(1, 1, 40 + k, 100, 'h10000 * (k + 1), 1, 0);
    cycleDrive(1, 1, 50, 90, 'h20000, 0, 0);
    repeat (3) cycleDrive(0, 0, 0, 0, 0, 1, 1);

    // Two events offered back-to-back during ACCUM.
    doReset();
    cycleDrive(1, 1, 62, 100, 'h30000, 0, 0);
    bus.inSampleTick = 1'b1;
    bus.inWaveMode   = 1'b0;
    expS = modelTick(0);
    stepClk();
    bus.inSampleTick = 1'b0;
    bus.inEventValid = 1'b1;
    bus.inEventOn    = 1'b1;
    bus.inNote       = 7'd64;
    bus.inVelocity   = 7'd80;
    bus.inStep       = PW'('h50000);
    checkVal("pendReadyFirst", bus.outEventReady, 1);
    stepClk();
    bus.inEventOn  = 1'b0;
    bus.inNote     = 7'd62;
    bus.inVelocity = 7'd0;
    checkVal("pendReadySecond", bus.outEventReady, 0);
    cnt = 0; strobeAt = -1; readyAt = -1;
    while (cnt < 40 && readyAt < 0) begin
      stepClk();
      cnt++;
      if (bus.outSampleReady) begin
        strobeAt = cnt;
        checkVal("pendSample", bus.outSample, expS);
      end
      if (bus.outEventReady) readyAt = cnt;
    end
    checkVal("pendReadyAfterStrobe", (strobeAt > 0 && readyAt > strobeAt) ? 1 : 0, 1);
    stepClk();
    bus.inEventValid = 1'b0;
    modelEvent(1, 64, 80, 'h50000, dummy);
    modelEvent(0, 62, 0, 0, dummy);
    checkVal("pendMask", bus.outActiveMask, modelMask());
    repeat (3) cycleDrive(0, 0, 0, 0, 0, 1, 0);

    // Random event/tick mix over a small note range so matches and overflow occur.
    doReset();
    for (int it = 0; it < 250; it++) begin
      r      = int'($urandom_range(0, 9));
      note   = 60 + int'($urandom_range(0, 5));
      vel    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      on     = ($urandom_range(0, 3) != 0);
      stp    = int'($urandom_range(1, 'h3FFFF));
      doEvt  = (r < 7);
      doTick = (r >= 4);
      if (doEvt || doTick) cycleDrive(doEvt, on, note, vel, stp, doTick, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of ACCUM.
    cycleDrive(1, 1, 70, 127, 'h40000, 0, 0);
    bus.inSampleTick = 1'b1;
    stepClk();
    bus.inSampleTick = 1'b0;
    stepClk();
    IN_RESET = 1'b1;
    stepClk();
    IN_RESET = 1'b0;
    modelReset();
    checkVal("midRstSample", bus.outSample, 'h800);
    checkVal("midRstSampleReady", bus.outSampleReady, 0);
    checkVal("midRstEventReady", bus.outEventReady, 1);
    checkVal("midRstMask", bus.outActiveMask, 0);
    checkVal("midRstDropped", bus.outDropped, 0);
    strobes = 0;
    repeat (NV + 3) begin
      stepClk();
      if (bus.outSampleReady) strobes++;
    end
    checkVal("midRstNoStrobe", strobes, 0);
    cycleDrive(0, 0, 0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
